// File: rtl/img_pkg.sv
// Shared types and constants for the image filter controller: FSM states,
// filter modes and the 3x3 window tap numbering (row-major, NW first).
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FETCH = 3'd2,
        ST_CAPT  = 3'd3,
        ST_CALC  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        MODE_COPY   = 2'd0,
        MODE_MEDIAN = 2'd1,
        MODE_GAUSS  = 2'd2,
        MODE_INVERT = 2'd3
    } mode_e;

    localparam int WIN_NW = 0;
    localparam int WIN_N  = 1;
    localparam int WIN_NE = 2;
    localparam int WIN_W  = 3;
    localparam int WIN_C  = 4;
    localparam int WIN_E  = 5;
    localparam int WIN_SW = 6;
    localparam int WIN_S  = 7;
    localparam int WIN_SE = 8;
    localparam int WIN_TAPS = 9;

    // Column (0..2, left to right) of a window tap.
    function automatic logic [1:0] win_col(input logic [3:0] k);
        unique case (k)
            4'd0, 4'd3, 4'd6: win_col = 2'd0;
            4'd1, 4'd4, 4'd7: win_col = 2'd1;
            default:          win_col = 2'd2;
        endcase
    endfunction

    // Row (0..2, top to bottom) of a window tap.
    function automatic logic [1:0] win_row(input logic [3:0] k);
        unique case (k)
            4'd0, 4'd1, 4'd2: win_row = 2'd0;
            4'd3, 4'd4, 4'd5: win_row = 2'd1;
            default:          win_row = 2'd2;
        endcase
    endfunction

    // log2 of the 1-2-1 Gaussian weight of a tap: corners 1, edges 2, centre 4.
    function automatic int gauss_shift(input int k);
        if (k == WIN_C) begin
            gauss_shift = 2;
        end else if (k == WIN_N || k == WIN_W || k == WIN_E || k == WIN_S) begin
            gauss_shift = 1;
        end else begin
            gauss_shift = 0;
        end
    endfunction

endpackage

// File: rtl/median9.sv
// Median of nine values: rank-based selection followed by a MED_LAT-deep
// register pipeline, so the result appears MED_LAT cycles after the inputs.
module median9
    import img_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int MED_LAT = 3
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [WIN_TAPS-1:0][D_WIDTH-1:0]  win_i,
    output logic [D_WIDTH-1:0]                med_o
);

    logic [D_WIDTH-1:0] med_comb;
    logic [D_WIDTH-1:0] pipe_q [MED_LAT];

    // A value is the median when at most 4 others are smaller and at least 5
    // (itself included) are not larger; duplicates all select the same value.
    always_comb begin
        logic [3:0] lt;
        logic [3:0] le;
        med_comb = '0;
        for (int i = 0; i < WIN_TAPS; i++) begin
            lt = '0;
            le = '0;
            for (int j = 0; j < WIN_TAPS; j++) begin
                if (win_i[j] < win_i[i]) lt = lt + 4'd1;
                if (win_i[j] <= win_i[i]) le = le + 4'd1;
            end
            if (lt <= 4'd4 && le >= 4'd5) med_comb = win_i[i];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < MED_LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= med_comb;
            for (int k = 1; k < MED_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign med_o = pipe_q[MED_LAT-1];

endmodule

// File: rtl/image_filter_ctrl.sv
// Frame controller: visits every pixel once in ascending order, fetching a 3x3
// window for interior pixels in median/Gaussian modes, then hands off to display.
module image_filter_ctrl
    import img_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int X_BITS  = 8,
    parameter int Y_BITS  = 8,
    parameter int MED_LAT = 3
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     START,
    input  logic [1:0]               MODE,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [X_BITS+Y_BITS-1:0] SRC_ADDR,
    input  logic [D_WIDTH-1:0]       SRC_DATA,
    output logic                     DST_WE,
    output logic [X_BITS+Y_BITS-1:0] DST_ADDR,
    output logic [D_WIDTH-1:0]       DST_DATA,
    input  logic [X_BITS+Y_BITS-1:0] VGA_ADDR,
    output logic                     VGA_EN
);

    localparam int A_WIDTH = X_BITS + Y_BITS;
    localparam int ACC_W   = D_WIDTH + 4;
    localparam int CNT_W   = 8;

    state_e                            state_q, state_d;
    mode_e                             mode_q, mode_d;
    logic [A_WIDTH-1:0]                pix_q, pix_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [WIN_TAPS-1:0][D_WIDTH-1:0]  win_q, win_d;

    logic [X_BITS-1:0]  pix_x, nbr_x;
    logic [Y_BITS-1:0]  pix_y, nbr_y;
    logic               pix_border, pix_direct, pix_last;
    logic [ACC_W-1:0]   gauss_sum;
    logic [D_WIDTH-1:0] gauss_out, med_out;

    assign pix_x      = pix_q[X_BITS-1:0];
    assign pix_y      = pix_q[A_WIDTH-1:X_BITS];
    assign pix_border = (pix_x == '0) || (pix_x == '1) || (pix_y == '0) || (pix_y == '1);
    assign pix_direct = (mode_q == MODE_COPY) || (mode_q == MODE_INVERT) || pix_border;
    assign pix_last   = (pix_q == '1);

    // Windows are interior only, so the +/-1 on each field never wraps.
    assign nbr_x = pix_x + X_BITS'(win_col(cnt_q[3:0])) - X_BITS'(1);
    assign nbr_y = pix_y + Y_BITS'(win_row(cnt_q[3:0])) - Y_BITS'(1);

    always_comb begin
        gauss_sum = '0;
        for (int k = 0; k < WIN_TAPS; k++) begin
            gauss_sum = gauss_sum + (ACC_W'(win_q[k]) << gauss_shift(k));
        end
    end
    assign gauss_out = gauss_sum[ACC_W-1:4];

    median9 #(
        .D_WIDTH (D_WIDTH),
        .MED_LAT (MED_LAT)
    ) u_median9 (
        .CLK   (CLK),
        .nRST  (nRST),
        .win_i (win_q),
        .med_o (med_out)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (START) state_d = ST_SCAN;
            ST_SCAN:          state_d = pix_direct ? ST_WRITE : ST_FETCH;
            ST_FETCH:         if (cnt_q == CNT_W'(WIN_SE)) state_d = ST_CAPT;
            ST_CAPT:          state_d = ST_CALC;
            ST_CALC:          if (cnt_q == CNT_W'(MED_LAT - 1)) state_d = ST_WRITE;
            ST_WRITE:         state_d = pix_last ? ST_DONE : ST_SCAN;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Each fetched word arrives one cycle after issue: FETCH step k captures tap k-1.
    always_comb begin
        pix_d  = pix_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        win_d  = win_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    pix_d  = '0;
                    mode_d = mode_e'(MODE);
                end
            end
            ST_SCAN: cnt_d = '0;
            ST_FETCH: begin
                for (int k = 0; k < WIN_TAPS - 1; k++) begin
                    if (cnt_q == CNT_W'(k + 1)) win_d[k] = SRC_DATA;
                end
                cnt_d = (cnt_q == CNT_W'(WIN_SE)) ? '0 : cnt_q + CNT_W'(1);
            end
            ST_CAPT: begin
                win_d[WIN_SE] = SRC_DATA;
                cnt_d         = '0;
            end
            ST_CALC:  cnt_d = cnt_q + CNT_W'(1);
            ST_WRITE: if (!pix_last) pix_d = pix_q + A_WIDTH'(1);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mode_q <= MODE_COPY;
            pix_q  <= '0;
            cnt_q  <= '0;
            win_q  <= '0;
        end else begin
            mode_q <= mode_d;
            pix_q  <= pix_d;
            cnt_q  <= cnt_d;
            win_q  <= win_d;
        end
    end

    always_comb begin
        BUSY     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        DONE     = (state_q == ST_DONE);
        VGA_EN   = (state_q == ST_DONE);
        DST_WE   = (state_q == ST_WRITE);
        DST_ADDR = (state_q == ST_DONE) ? VGA_ADDR : pix_q;
        SRC_ADDR = pix_q;
        DST_DATA = '0;
        unique case (state_q)
            ST_FETCH: SRC_ADDR = {nbr_y, nbr_x};
            ST_DONE:  SRC_ADDR = VGA_ADDR;
            default: ;
        endcase
        if (state_q == ST_WRITE) begin
            unique case (mode_q)
                MODE_COPY:   DST_DATA = SRC_DATA;
                MODE_INVERT: DST_DATA = ~SRC_DATA;
                MODE_MEDIAN: DST_DATA = pix_direct ? SRC_DATA : med_out;
                default:     DST_DATA = pix_direct ? SRC_DATA : gauss_out;
            endcase
        end
    end

endmodule

// File: tb/tb_image_filter_ctrl.sv
// Bench for image_filter_ctrl on an 8x8 image: pixel-probe table, full-frame
// scoreboard against an arithmetic reference, reset abort and ignored START.
module tb_image_filter_ctrl;

  localparam int DW   = 8;
  localparam int XB   = 3;
  localparam int YB   = 3;
  localparam int ML   = 3;
  localparam int AW   = XB + YB;
  localparam int SIDE = 8;
  localparam int NPIX = SIDE * SIDE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          busy, done, dst_we, vga_en;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] src_data, dst_data;

  logic [DW-1:0]    src_mem [NPIX];
  logic [DW-1:0]    dst_img [NPIX];
  logic [AW-1:0]    got_addr_q[$];
  logic [DW-1:0]    got_data_q[$];
  logic [AW+DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pat;
    int mode;
    int x;
    int y;
    int exp;
  } vec_t;
  vec_t vecs[$];

  // ---------------- clock / reset / memories ----------------
  always #5 clk = ~clk;

  image_filter_ctrl #(
    .D_WIDTH (DW),
    .X_BITS  (XB),
    .Y_BITS  (YB),
    .MED_LAT (ML)
  ) dut (
    .CLK      (clk),
    .nRST     (rst_n),
    .START    (start),
    .MODE     (mode),
    .BUSY     (busy),
    .DONE     (done),
    .SRC_ADDR (src_addr),
    .SRC_DATA (src_data),
    .DST_WE   (dst_we),
    .DST_ADDR (dst_addr),
    .DST_DATA (dst_data),
    .VGA_ADDR (vga_addr),
    .VGA_EN   (vga_en)
  );

  always @(posedge clk) src_data <= src_mem[src_addr];

  always @(negedge clk) begin
    if (dst_we === 1'b1) begin
      got_addr_q.push_back(dst_addr);
      got_data_q.push_back(dst_data);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int src_at(int x, int y);
    return int'(src_mem[y*SIDE + x]);
  endfunction

  function automatic bit is_border(int x, int y);
    return (x == 0) || (y == 0) || (x == SIDE-1) || (y == SIDE-1);
  endfunction

  // Reference: what each destination pixel must be, from the filter definitions.
  function automatic int ref_pixel(int m, int x, int y);
    int q[$];
    int sum;
    if (m == 0) return src_at(x, y);
    if (m == 3) return (~src_at(x, y)) & 255;
    if (is_border(x, y)) return src_at(x, y);
    sum = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        q.push_back(src_at(x + dx, y + dy));
        sum += src_at(x + dx, y + dy) * (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
      end
    end
    if (m == 1) begin
      q.sort();
      return q[4];
    end
    return (sum >> 4) & 255;
  endfunction

  task automatic build_expected(input int m, output int exp_busy);
    exp_q.delete();
    exp_busy = 0;
    for (int y = 0; y < SIDE; y++) begin
      for (int x = 0; x < SIDE; x++) begin
        exp_q.push_back({AW'(y*SIDE + x), DW'(ref_pixel(m, x, y))});
        if (m == 0 || m == 3 || is_border(x, y)) exp_busy += 2;
        else exp_busy += 12 + ML;
      end
    end
  endtask

  task automatic fill_pattern(input int p);
    for (int y = 0; y < SIDE; y++) begin
      for (int x = 0; x < SIDE; x++) begin
        case (p)
          0: src_mem[y*SIDE + x] = DW'(y*SIDE + x);
          1: src_mem[y*SIDE + x] = (x == 3 && y == 3) ? 8'd255 : 8'd10;
          2: src_mem[y*SIDE + x] = (x == 4 && y == 4) ? 8'd32 : 8'd16;
          3: src_mem[y*SIDE + x] = 8'h0F;
          4: src_mem[y*SIDE + x] = is_border(x, y) ? 8'd200 : 8'd0;
          default: src_mem[y*SIDE + x] = DW'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  // ---------------- driver: one full frame, scoreboarded ----------------
  task automatic run_frame(input logic [1:0] m, input bit mid_start, input string tag);
    int cycles;
    int busy_cyc;
    int exp_busy;
    int n;
    build_expected(int'(m), exp_busy);
    got_addr_q.delete();
    got_data_q.delete();
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    cycles   = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && cycles < 4000) begin
      if (busy === 1'b1) busy_cyc++;
      if (mid_start && cycles == 100) begin
        start = 1'b1;
        mode  = m ^ 2'b11;
      end
      if (mid_start && cycles == 101) start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_reached"}, 32'(done === 1'b1), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    check({tag, "_vga_en"}, 32'(vga_en), 32'd1);
    check({tag, "_we_idle"}, 32'(dst_we), 32'd0);
    check({tag, "_write_count"}, 32'(got_addr_q.size()), 32'(exp_q.size()));
    n = (got_addr_q.size() < exp_q.size()) ? got_addr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_write%0d", tag, i), 32'({got_addr_q[i], got_data_q[i]}), 32'(exp_q[i]));
      dst_img[got_addr_q[i]] = got_data_q[i];
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int last_pat;
    int last_mode;
    int cycles;
    logic [AW-1:0] va;

    for (int i = 0; i < NPIX; i++) src_mem[i] = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vga_en", 32'(vga_en), 32'd0);
    check("rst_dst_we", 32'(dst_we), 32'd0);
    check("rst_src_addr", 32'(src_addr), 32'd0);
    check("rst_dst_data", 32'(dst_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // {pattern, mode, x, y, expected dst(x,y)}
    vecs.push_back('{0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 5, 2, 21});
    vecs.push_back('{0, 0, 7, 7, 63});
    vecs.push_back('{1, 1, 3, 3, 10});
    vecs.push_back('{1, 1, 0, 0, 10});
    vecs.push_back('{1, 1, 2, 3, 10});
    vecs.push_back('{2, 2, 4, 4, 20});
    vecs.push_back('{2, 2, 3, 4, 18});
    vecs.push_back('{2, 2, 4, 3, 18});
    vecs.push_back('{2, 2, 3, 3, 17});
    vecs.push_back('{2, 2, 5, 5, 17});
    vecs.push_back('{2, 2, 0, 0, 16});
    vecs.push_back('{2, 2, 6, 6, 16});
    vecs.push_back('{3, 3, 0, 0, 8'hF0});
    vecs.push_back('{3, 3, 4, 4, 8'hF0});
    vecs.push_back('{3, 3, 7, 0, 8'hF0});
    vecs.push_back('{4, 1, 0, 0, 200});
    vecs.push_back('{4, 1, 1, 1, 200});
    vecs.push_back('{4, 1, 6, 1, 200});
    vecs.push_back('{4, 1, 2, 2, 0});
    vecs.push_back('{4, 1, 3, 1, 0});

    last_pat  = -1;
    last_mode = -1;
    foreach (vecs[i]) begin
      if (vecs[i].pat != last_pat || vecs[i].mode != last_mode) begin
        fill_pattern(vecs[i].pat);
        for (int k = 0; k < NPIX; k++) dst_img[k] = '0;
        run_frame(2'(vecs[i].mode), 1'b0, $sformatf("pat%0d", vecs[i].pat));
        last_pat  = vecs[i].pat;
        last_mode = vecs[i].mode;
      end
      check($sformatf("vec%0d_dst_%0d_%0d", i, vecs[i].x, vecs[i].y),
            32'(dst_img[vecs[i].y*SIDE + vecs[i].x]), 32'(vecs[i].exp));
    end

    // Display readout: both address outputs follow VGA_ADDR while DONE.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      va = AW'($urandom_range(0, NPIX-1));
      vga_addr = va;
      #1;
      check($sformatf("vga%0d_dst_addr", i), 32'(dst_addr), 32'(va));
      check($sformatf("vga%0d_src_addr", i), 32'(src_addr), 32'(va));
      check($sformatf("vga%0d_we", i), 32'(dst_we), 32'd0);
    end

    // START and MODE changes mid-frame must not disturb the running frame.
    fill_pattern(9);
    run_frame(2'd1, 1'b1, "midstart_med");
    fill_pattern(9);
    run_frame(2'd2, 1'b1, "midstart_gauss");

    // Random images in every mode.
    for (int r = 0; r < 4; r++) begin
      fill_pattern(9);
      run_frame(2'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", r));
    end

    // Reset after the 20th write aborts the frame at once.
    fill_pattern(9);
    got_addr_q.delete();
    got_data_q.delete();
    @(negedge clk);
    mode  = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (got_addr_q.size() < 20 && cycles < 500) begin
      @(posedge clk);
      cycles++;
    end
    check("abort_reached_20", 32'(got_addr_q.size()), 32'd20);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(dst_we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_more_writes", 32'(got_addr_q.size()), 32'd20);
    check("abort_idle_busy", 32'(busy), 32'd0);
    run_frame(2'd0, 1'b0, "after_abort");
    if (got_addr_q.size() > 0) check("after_abort_first_addr", 32'(got_addr_q[0]), 32'd0);
    else check("after_abort_first_addr_present", 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_filter_ctrl.md
IMAGE_FILTER_CTRL -- requirements
Module: image_filter_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter X_BITS, default 8, log2 of image width.
REQ-003 SHALL have parameter Y_BITS, default 8, log2 of image height.
REQ-004 SHALL have parameter MED_LAT, default 3, fixed latency in cycles of the median sub-module.
REQ-005 SHALL derive localparam A_WIDTH = X_BITS+Y_BITS; pixel address = {y, x}.
REQ-006 SHALL have one clock, CLK; reset nRST is asynchronous and active-low.
REQ-007 Ports:
- CLK input 1: clock.
- nRST input 1: asynchronous active-low reset.
- START input 1: one-cycle frame start request.
- MODE input 2: 0 copy, 1 median 3x3, 2 Gaussian 3x3 (1-2-1), 3 invert.
- BUSY output 1: frame in progress.
- DONE output 1: frame complete; held until the next accepted START.
- SRC_ADDR output A_WIDTH: source image read address.
- SRC_DATA input D_WIDTH: source read data, valid one cycle after SRC_ADDR.
- DST_WE output 1: destination write strobe.
- DST_ADDR output A_WIDTH: destination address (write address, or VGA_ADDR when DONE).
- DST_DATA output D_WIDTH: destination write data.
- VGA_ADDR input A_WIDTH: display read address.
- VGA_EN output 1: display readout enabled.

Function
REQ-008 SHALL accept START only in IDLE or DONE; START SHALL be ignored while BUSY=1.
REQ-009 SHALL latch MODE on the accepted START and hold it for the whole frame.
REQ-010 SHALL use states IDLE, SCAN, FETCH, CAPT, CALC, WRITE, DONE.
REQ-011 Transitions:
- IDLE/DONE to SCAN on START, with pix=0.
- SCAN drives SRC_ADDR=pix; goes to WRITE if the pixel is direct, else to FETCH.
- FETCH lasts 9 cycles issuing NW,N,NE,W,C,E,SW,S,SE; each word is captured one cycle after issue.
- CAPT lasts 1 cycle and captures SE.
- CALC lasts exactly MED_LAT cycles in modes 1 and 2.
- WRITE lasts 1 cycle; then DONE if pix is the last address, else SCAN with pix+1.
REQ-012 Direct pixels:
- all pixels in modes 0 and 3.
- border pixels (x=0, x=max, y=0, y=max) in modes 1 and 2, written as the raw source value.
REQ-013 Neighbour addresses SHALL be formed by ±1 on the x and y fields separately; no wrap occurs because windows are interior only.
REQ-014 WRITE SHALL assert DST_WE=1 for exactly one cycle, with DST_ADDR=pix and DST_DATA as follows:
- mode 0: SRC_DATA.
- mode 3: ~SRC_DATA.
- mode 1 interior: median of the 9 window values.
- mode 2 interior: (NW+NE+SW+SE+2(N+W+E+S)+4C)>>4, accumulated in D_WIDTH+4 bits, truncated.
REQ-015 Pixel cost SHALL be 2 cycles for direct pixels and 12+MED_LAT cycles for windowed pixels.
REQ-016 BUSY SHALL be 1 in every state except IDLE and DONE.
REQ-017 In DONE: DONE=1, VGA_EN=1, DST_ADDR=VGA_ADDR combinationally, SRC_ADDR=VGA_ADDR, DST_WE=0.
REQ-018 Each address SHALL be written exactly once per frame, in ascending order.

Reset
REQ-019 nRST low SHALL force, asynchronously:
- state=IDLE, pix=0, latched mode=0.
- BUSY, DONE, VGA_EN, DST_WE = 0.
- SRC_ADDR, DST_DATA, window registers = 0.
REQ-020 Reset mid-frame SHALL abort the frame with no further writes; the next START restarts at address 0.

Structure
REQ-021 A shared package img_pkg SHALL hold the state enum, the mode enum, and the window index constants (NW..SE = 0..8).
REQ-022 The median SHALL be a sub-module median9: 9 D_WIDTH inputs, pipelined, latency MED_LAT, with CLK and nRST.

Verification (X_BITS=Y_BITS=3, D_WIDTH=8, 8x8 image)
REQ-023 Mode 0, src[a]=a, START: 64 writes, dst[a]=a, ascending; BUSY high 128 cycles; then DONE=1, VGA_EN=1.
REQ-024 Mode 1, all src=10 except (3,3)=255: every dst=10.
REQ-025 Mode 2, all src=16 except (4,4)=32: dst(4,4)=20, dst(3,4)=18, dst(3,3)=17, all others 16.
REQ-026 Mode 3, src=0x0F everywhere: every dst=0xF0, border included.
REQ-027 Mode 1, border=200, interior=0: border 200, dst(1,1)=200 (5 of 9 values are 200), dst(2,2)=0.
REQ-028 Reset and ignored START:
- pulse nRST low after the 20th write: DST_WE=0 and BUSY=0 immediately.
- next START: first write is address 0.
- a START pulsed mid-frame changes neither mode nor pix.
